mem_bus_arbiter: RTL and testbench

Two-port arbiter sharing a single memory bus between the instruction-fetch port (port 0) and the data-access port (port 1) of the dynamic pipeline. It accepts one request at a time using round-robin priority, captures that request through a mux2 select path, drives the shared bus until the slave completes or a watchdog expires, and returns a registered response to the winning port. Only one transaction is in flight at a time.

---
 rtl/cpu_defs.sv | 16 +
 rtl/mux2.sv | 17 +
 rtl/mem_bus_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared definitions for the memory bus arbiter.
//   arb_state_t : arbiter FSM encoding (IDLE / BUSY0 / BUSY1)
//   PORT_IF     : index of the instruction-fetch port
//   PORT_MEM    : index of the data-access port
package cpu_defs;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY0 = 2'd1,
      BUSY1 = 2'd2
   } arb_state_t;

   localparam logic PORT_IF  = 1'b0;
   localparam logic PORT_MEM = 1'b1;

endpackage

// File: rtl/mux2.sv
// Generic two-input multiplexer.
//   sel : 0 selects in0, 1 selects in1
//   in0 : WIDTH-bit input 0
//   in1 : WIDTH-bit input 1
//   out : selected value
module mux2 #(
   parameter int WIDTH = 1
) (
   input  logic             sel,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   output logic [WIDTH-1:0] out
);

   assign out = sel ? in1 : in0;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter for a single shared memory bus.
// Port 0 is instruction fetch, port 1 is data access. One transaction is in
// flight at a time; a watchdog aborts it after TIMEOUT bus cycles.
//   clk, rst              : clock, synchronous active-high reset
//   reqN_valid/we/addr/wdata : request from port N (held until accepted)
//   reqN_ready            : combinational accept strobe for port N
//   rspN_valid            : one-cycle response pulse to port N
//   rsp_rdata, rsp_err    : shared response data / timeout flag
//   bus_valid/we/addr/wdata/sel : shared bus master side
//   bus_done, bus_rdata   : slave completion strobe and read data
//
// state | meaning
// ------+------------------------------------------------
// IDLE  | no transaction; arbitrate and accept a request
// BUSY0 | bus owned by port 0, waiting for done/timeout
// BUSY1 | bus owned by port 1, waiting for done/timeout
module mem_bus_arbiter
   import cpu_defs::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              req0_valid,
   input  logic              req0_we,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_ready,

   input  logic              req1_valid,
   input  logic              req1_we,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_ready,

   output logic              rsp0_valid,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,

   output logic              bus_valid,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   output logic              bus_sel,
   input  logic              bus_done,
   input  logic [DATA_W-1:0] bus_rdata
);

   localparam int CNT_W = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   arb_state_t        state;
   arb_state_t        state_nxt;
   logic              last_grant;
   logic [CNT_W-1:0]  cnt;

   logic              win;
   logic              accept;
   logic              busy;
   logic              finish;

   logic              win_we;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_wdata;

   // On a tie the port that did not win last time goes first.
   assign win  = req1_valid && (!req0_valid || (last_grant == PORT_IF));
   assign busy = (state == BUSY0) || (state == BUSY1);

   // bus_done is checked first so a completion on the expiry cycle is normal.
   assign finish = busy && (bus_done || (cnt == CNT_LAST));

   mux2 #(.WIDTH(ADDR_W)) u_mux_addr (
      .sel (win),
      .in0 (req0_addr),
      .in1 (req1_addr),
      .out (win_addr)
   );

   mux2 #(.WIDTH(DATA_W)) u_mux_wdata (
      .sel (win),
      .in0 (req0_wdata),
      .in1 (req1_wdata),
      .out (win_wdata)
   );

   mux2 #(.WIDTH(1)) u_mux_we (
      .sel (win),
      .in0 (req0_we),
      .in1 (req1_we),
      .out (win_we)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      accept     = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      unique case (state)
         IDLE: begin
            if (!rst && (req0_valid || req1_valid)) begin
               accept     = 1'b1;
               req0_ready = (win == PORT_IF);
               req1_ready = (win == PORT_MEM);
               state_nxt  = (win == PORT_MEM) ? BUSY1 : BUSY0;
            end
         end
         BUSY0, BUSY1: begin
            if (finish) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= PORT_MEM;
         cnt        <= '0;
         bus_valid  <= 1'b0;
         bus_we     <= 1'b0;
         bus_addr   <= '0;
         bus_wdata  <= '0;
         bus_sel    <= PORT_IF;
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp_rdata  <= '0;
         rsp_err    <= 1'b0;
      end else begin
         rsp0_valid <= finish && (state == BUSY0);
         rsp1_valid <= finish && (state == BUSY1);

         if (finish) begin
            rsp_rdata <= bus_done ? bus_rdata : '0;
            rsp_err   <= !bus_done;
         end

         if (accept) begin
            bus_valid  <= 1'b1;
            bus_we     <= win_we;
            bus_addr   <= win_addr;
            bus_wdata  <= win_wdata;
            bus_sel    <= win;
            last_grant <= win;
            cnt        <= '0;
         end else if (finish) begin
            bus_valid <= 1'b0;
         end else if (busy && !bus_done) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter (TIMEOUT = 4).
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req0_we, req0_ready;
   logic [31:0] req0_addr, req0_wdata;
   logic        req1_valid, req1_we, req1_ready;
   logic [31:0] req1_addr, req1_wdata;
   logic        rsp0_valid, rsp1_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic        bus_valid, bus_we, bus_sel, bus_done;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;

   int ntests = 0;
   int nfail  = 0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_we    (req0_we),
      .req0_addr  (req0_addr),
      .req0_wdata (req0_wdata),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_we    (req1_we),
      .req1_addr  (req1_addr),
      .req1_wdata (req1_wdata),
      .req1_ready (req1_ready),
      .rsp0_valid (rsp0_valid),
      .rsp1_valid (rsp1_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .bus_valid  (bus_valid),
      .bus_we     (bus_we),
      .bus_addr   (bus_addr),
      .bus_wdata  (bus_wdata),
      .bus_sel    (bus_sel),
      .bus_done   (bus_done),
      .bus_rdata  (bus_rdata)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      logic e;
      rst        = 1'b1;
      req0_valid = 1'b1;
      req0_we    = 1'b0;
      req0_addr  = 32'h0;
      req0_wdata = 32'h0;
      req1_valid = 1'b0;
      req1_we    = 1'b0;
      req1_addr  = 32'h0;
      req1_wdata = 32'h0;
      bus_done   = 1'b0;
      bus_rdata  = 32'h0;

      // reset values
      step();
      step();
      chk1 ("rst_ready0",   req0_ready, 1'b0);
      chk1 ("rst_bus_valid", bus_valid, 1'b0);
      chk1 ("rst_bus_we",   bus_we,     1'b0);
      chk32("rst_bus_addr", bus_addr,   32'h0);
      chk32("rst_bus_wdata", bus_wdata, 32'h0);
      chk1 ("rst_bus_sel",  bus_sel,    1'b0);
      chk1 ("rst_rsp0",     rsp0_valid, 1'b0);
      chk1 ("rst_rsp1",     rsp1_valid, 1'b0);
      chk32("rst_rdata",    rsp_rdata,  32'h0);
      chk1 ("rst_err",      rsp_err,    1'b0);

      // first tie after reset goes to port 0
      rst        = 1'b0;
      req1_valid = 1'b1;
      settle();
      chk1("tie0_ready0", req0_ready, 1'b1);
      chk1("tie0_ready1", req1_ready, 1'b0);
      req1_valid = 1'b0;

      // single read on port 0: accept T, done in T+3, response in T+4
      req0_addr = 32'h100;
      settle();
      chk1("rd_ready0", req0_ready, 1'b1);
      chk1("rd_ready1", req1_ready, 1'b0);
      step();
      req0_valid = 1'b0;
      settle();
      chk1 ("rd_valid_t1", bus_valid, 1'b1);
      chk32("rd_addr",     bus_addr,  32'h100);
      chk1 ("rd_sel",      bus_sel,   1'b0);
      chk1 ("rd_we",       bus_we,    1'b0);
      chk1 ("rd_busy_rdy", req0_ready, 1'b0);
      step();
      chk1 ("rd_valid_t2", bus_valid, 1'b1);
      step();
      bus_done  = 1'b1;
      bus_rdata = 32'hDEADBEEF;
      settle();
      chk1 ("rd_valid_t3", bus_valid, 1'b1);
      step();
      bus_done  = 1'b0;
      bus_rdata = 32'h0;
      settle();
      chk1 ("rd_rsp0",     rsp0_valid, 1'b1);
      chk1 ("rd_rsp1",     rsp1_valid, 1'b0);
      chk32("rd_rdata",    rsp_rdata,  32'hDEADBEEF);
      chk1 ("rd_err",      rsp_err,    1'b0);
      chk1 ("rd_valid_t4", bus_valid,  1'b0);
      step();
      chk1 ("rd_rsp0_end", rsp0_valid, 1'b0);
      chk32("rd_addr_hold", bus_addr,  32'h100);

      // stray completion in IDLE
      bus_done  = 1'b1;
      bus_rdata = 32'h00000BAD;
      step();
      bus_done  = 1'b0;
      settle();
      chk1 ("stray_rsp0",  rsp0_valid, 1'b0);
      chk1 ("stray_rsp1",  rsp1_valid, 1'b0);
      chk1 ("stray_valid", bus_valid,  1'b0);
      chk32("stray_rdata", rsp_rdata,  32'hDEADBEEF);

      // write on port 1, done in T+1
      req1_valid = 1'b1;
      req1_we    = 1'b1;
      req1_addr  = 32'h2000;
      req1_wdata = 32'h12345678;
      settle();
      chk1("wr_ready1", req1_ready, 1'b1);
      chk1("wr_ready0", req0_ready, 1'b0);
      step();
      req1_valid = 1'b0;
      bus_done   = 1'b1;
      bus_rdata  = 32'h55;
      settle();
      chk1 ("wr_valid", bus_valid, 1'b1);
      chk1 ("wr_we",    bus_we,    1'b1);
      chk32("wr_wdata", bus_wdata, 32'h12345678);
      chk32("wr_addr",  bus_addr,  32'h2000);
      chk1 ("wr_sel",   bus_sel,   1'b1);
      step();
      bus_done = 1'b0;
      req1_we  = 1'b0;
      settle();
      chk1 ("wr_rsp1",     rsp1_valid, 1'b1);
      chk1 ("wr_rsp0",     rsp0_valid, 1'b0);
      chk1 ("wr_err",      rsp_err,    1'b0);
      chk32("wr_rdata",    rsp_rdata,  32'h55);
      chk1 ("wr_idle",     bus_valid,  1'b0);
      chk1 ("wr_sel_hold", bus_sel,    1'b1);

      // round robin under contention, done always in T+1: grants 0,1,0,1
      req0_addr  = 32'h10;
      req1_addr  = 32'h20;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      settle();
      for (int i = 0; i < 4; i++) begin
         e = (i % 2 == 1);
         chk1("rr_ready0", req0_ready, !e);
         chk1("rr_ready1", req1_ready, e);
         step();
         bus_done  = 1'b1;
         bus_rdata = 32'h100 + 32'(i);
         settle();
         chk1 ("rr_valid",  bus_valid, 1'b1);
         chk1 ("rr_sel",    bus_sel,   e);
         chk32("rr_addr",   bus_addr,  e ? 32'h20 : 32'h10);
         chk1 ("rr_busy0",  req0_ready, 1'b0);
         chk1 ("rr_busy1",  req1_ready, 1'b0);
         step();
         bus_done = 1'b0;
         if (i == 3) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
         end
         settle();
         chk1 ("rr_rsp0",  rsp0_valid, !e);
         chk1 ("rr_rsp1",  rsp1_valid, e);
         chk32("rr_rdata", rsp_rdata,  32'h100 + 32'(i));
      end

      // timeout on port 0: bus_valid for exactly 4 cycles, error in T+5
      req0_valid = 1'b1;
      req0_addr  = 32'h300;
      settle();
      chk1("to_ready0", req0_ready, 1'b1);
      step();
      req0_valid = 1'b0;
      settle();
      for (int k = 0; k < 4; k++) begin
         chk1("to_valid", bus_valid,  1'b1);
         chk1("to_norsp", rsp0_valid, 1'b0);
         step();
      end
      chk1 ("to_rsp0",  rsp0_valid, 1'b1);
      chk1 ("to_rsp1",  rsp1_valid, 1'b0);
      chk1 ("to_err",   rsp_err,    1'b1);
      chk32("to_rdata", rsp_rdata,  32'h0);
      chk1 ("to_idle",  bus_valid,  1'b0);
      step();
      chk1 ("to_rsp_end", rsp0_valid, 1'b0);
      chk1 ("to_idle2",   bus_valid,  1'b0);

      // done on the expiry cycle (4th bus cycle) wins over the timeout
      req0_valid = 1'b1;
      settle();
      chk1("dx_ready0", req0_ready, 1'b1);
      step();
      req0_valid = 1'b0;
      step();
      step();
      step();
      bus_done  = 1'b1;
      bus_rdata = 32'hA5A5A5A5;
      settle();
      chk1("dx_valid4", bus_valid, 1'b1);
      step();
      bus_done = 1'b0;
      settle();
      chk1 ("dx_rsp0",  rsp0_valid, 1'b1);
      chk1 ("dx_err",   rsp_err,    1'b0);
      chk32("dx_rdata", rsp_rdata,  32'hA5A5A5A5);

      // reset in BUSY1 with a completion in the same cycle
      req1_valid = 1'b1;
      settle();
      chk1("mr_ready1", req1_ready, 1'b1);
      step();
      req1_valid = 1'b0;
      settle();
      chk1("mr_sel",   bus_sel,   1'b1);
      chk1("mr_valid", bus_valid, 1'b1);
      rst       = 1'b1;
      bus_done  = 1'b1;
      bus_rdata = 32'h77;
      req0_valid = 1'b1;
      settle();
      chk1("mr_rst_ready0", req0_ready, 1'b0);
      step();
      rst        = 1'b0;
      bus_done   = 1'b0;
      req1_valid = 1'b1;
      settle();
      chk1 ("mr_valid_low", bus_valid,  1'b0);
      chk1 ("mr_no_rsp1",   rsp1_valid, 1'b0);
      chk1 ("mr_no_rsp0",   rsp0_valid, 1'b0);
      chk32("mr_rdata",     rsp_rdata,  32'h0);
      chk1 ("mr_ready0",    req0_ready, 1'b1);
      chk1 ("mr_ready1b",   req1_ready, 1'b0);
      step();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      bus_done   = 1'b1;
      bus_rdata  = 32'h99;
      settle();
      chk1("mr_sel0",    bus_sel,   1'b0);
      chk1("mr_valid2",  bus_valid, 1'b1);
      step();
      bus_done = 1'b0;
      settle();
      chk1 ("mr_rsp0",   rsp0_valid, 1'b1);
      chk32("mr_rdata2", rsp_rdata,  32'h99);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
